// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the hazard scoreboard: register count,
// field widths and the producer latency codes carried on issue_lat.
package hazard_scoreboard_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned LAT_W    = 2;

  typedef enum logic [LAT_W-1:0] {
    LAT_ALU      = 2'd0,
    LAT_LOAD     = 2'd1,
    LAT_MUL      = 2'd2,
    LAT_MUL_LONG = 2'd3
  } lat_e;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's scoreboard slot: a saturating countdown to
// forwardability plus a pending bit that tracks the uncommitted writer.
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_hit,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             wb_hit,
  output logic [LAT_W-1:0] cnt,
  output logic             pending
);

  logic [LAT_W-1:0] cnt_q;
  logic             pend_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else if (issue_hit) begin
      // Youngest writer governs; a same-edge write-back of an older value loses.
      cnt_q  <= issue_lat;
      pend_q <= 1'b1;
    end else begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (wb_hit) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign cnt     = cnt_q;
  assign pending = pend_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: stalls ID while a source register's producer is not
// yet forwardable. Optional stall_cycles counter under SCOREBOARD_PERF_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_regwrite,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic                use_rs,
  input  logic                use_rt,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  logic [LAT_W-1:0] cnt_q   [1:NUM_REGS-1];
  logic             pend_q  [1:NUM_REGS-1];
  logic [LAT_W-1:0] cnt_all [NUM_REGS];
  logic             issue_go;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    sb_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .issue_hit (issue_go && issue_regwrite && (issue_rd == REG_W'(i))),
      .issue_lat (issue_lat),
      .wb_hit    (wb_valid && (wb_rd == REG_W'(i))),
      .cnt       (cnt_q[i]),
      .pending   (pend_q[i])
    );
  end

  // Register 0 has no slot; it reads back as permanently idle.
  always_comb begin
    cnt_all[0] = '0;
    pending    = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      cnt_all[i] = cnt_q[i];
      pending[i] = pend_q[i];
    end
  end

  always_comb begin
    stall    = (use_rs && (rs != '0) && (cnt_all[rs] != '0)) ||
               (use_rt && (rt != '0) && (cnt_all[rt] != '0));
    issue_go = issue_valid && !stall;
  end

`ifdef SCOREBOARD_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
